regfile_mp_sb: RTL
==================

Name: regfile_mp_sb

Overview:
Parametrised successor of the single-write, two-read general-purpose register file. It provides NUM_RD combinational read ports and two write ports: port A for the ALU/EX path and port B for the MEM/WB path. Each read port has a same-cycle write bypass. A per-register pending-write scoreboard lets the ID stage detect load-use and multi-cycle hazards. The block sits between ID (reads, issue marking) and MEM/WB (writes).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; depth = 2**ADDR_W
NUM_RD, 2, number of read ports, legal range 1..4
ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes; 0 = register 0 behaves as an ordinary register

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous reset, active-low; sampled on the rising edge of clk
we_a  in  1  write-port A enable
waddr_a  in  ADDR_W  write-port A address
wdata_a  in  DATA_W  write-port A data
we_b  in  1  write-port B enable; B is the younger write and has priority over A
waddr_b  in  ADDR_W  write-port B address
wdata_b  in  DATA_W  write-port B data
re  in  NUM_RD  per-port read enable
raddr  in  NUM_RD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
rdata  out  NUM_RD*DATA_W  read data, port i at bits [i*DATA_W +: DATA_W]
rbusy  out  NUM_RD  per-port flag: the addressed register has an outstanding producer
iss_v  in  1  issue-mark enable: an instruction that will write iss_addr has left ID
iss_addr  in  ADDR_W  destination register being marked pending
busy_vec  out  2**ADDR_W  raw scoreboard state, for debug and the stall unit

Behaviour:
- Storage: 2**ADDR_W x DATA_W registers and a busy bit per register.
- Reset, rst low at a clock edge:
  - all registers are cleared to 0 and all busy bits to 0;
  - writes and iss_v on that edge are ignored;
  - while rst is low, rdata = 0 and rbusy = 0 on every port, combinationally.
- Write, at the clock edge while rst is high:
  - we_a writes wdata_a to waddr_a; we_b writes wdata_b to waddr_b.
  - If both are enabled to the same address, only wdata_b is stored.
  - If ZERO_REG = 1, writes to address 0 are dropped.
- Read, combinational, evaluated per port i in priority order:
  1. rst low -> 0.
  2. re[i] = 0 -> 0.
  3. ZERO_REG = 1 and raddr_i = 0 -> 0.
  4. we_b and waddr_b = raddr_i -> wdata_b.
  5. we_a and waddr_a = raddr_i -> wdata_a.
  6. Otherwise -> stored value.
  Read latency is 0 cycles. The bypass in steps 4-5 makes a write and a read of the same register in the same cycle return the new value.
- Scoreboard, at the clock edge while rst is high, evaluated per register r:
  - set if iss_v and iss_addr = r;
  - else clear if (we_a and waddr_a = r) or (we_b and waddr_b = r);
  - else hold.
  - Set beats clear in the same cycle: the new producer stays outstanding.
  - If ZERO_REG = 1, register 0 is never set.
  - Setting an already-busy register keeps it busy. Multiple outstanding producers of one register are not counted; the pipeline guarantees in-order writeback.
- rbusy[i] = re[i] and busy[raddr_i] and not (a write to raddr_i this cycle). This holds except when rst is low or (ZERO_REG = 1 and raddr_i = 0), in which case rbusy[i] = 0. Because a same-cycle write counts as bypassed, the read is not busy.
- busy_vec is a registered copy of the busy bits and ignores the bypass.
- Reset mid-operation discards all pending marks; the pipeline is flushed alongside.
- raddr, waddr and iss_addr are always in range; there is no out-of-range case.

Test Plan:
1. Reset then read-after-write: hold rst = 0 for 2 cycles, release. Write 0x12345678 to r5 via port A. Next cycle read r5 on port 0 -> 0x12345678; port 1 reads r6 -> 0.
2. Dual-write conflict and bypass: in one cycle, we_a writes r7 = 0xAAAA0000 and we_b writes r7 = 0x0000BBBB, with port 0 reading r7. Same cycle: rdata0 = 0x0000BBBB. Next cycle, with writes off: rdata0 = 0x0000BBBB.
3. Zero register: write 0xFFFFFFFF to r0 on both ports and iss_v with iss_addr = 0. Read r0 -> 0, rbusy = 0, busy_vec[0] = 0. Repeat with ZERO_REG = 0 -> read 0xFFFFFFFF.
4. Scoreboard lifecycle: iss_v marks r9. Next cycle, a read of r9 gives rbusy = 1. Two cycles later we_b writes r9 = 0x55: that cycle rbusy = 0 and rdata = 0x55; next cycle busy_vec[9] = 0.
5. Set-beats-clear: in one cycle, iss_v marks r3 and we_a writes r3. Next cycle busy_vec[3] = 1 and a read of r3 returns the written data with rbusy = 1.
6. Reset mid-operation: mark r4 busy, write r4 = 0x77, assert rst low for 1 cycle with we_a = 1. Afterwards r4 reads 0 and busy_vec = 0. Run with NUM_RD = 4 and check all four ports independently.

Source files
------------

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with two write ports, per-port same-cycle bypass
// and a per-register pending-write scoreboard for ID-stage hazard detection.
module regfile_mp_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we_a,
  input  logic [ADDR_W-1:0]        waddr_a,
  input  logic [DATA_W-1:0]        wdata_a,
  input  logic                     we_b,
  input  logic [ADDR_W-1:0]        waddr_b,
  input  logic [DATA_W-1:0]        wdata_b,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     iss_v,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [(2**ADDR_W)-1:0]   busy_vec
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;

  logic wr_ok_a, wr_ok_b;
  assign wr_ok_a = we_a && !(ZERO_REG && (waddr_a == '0));
  assign wr_ok_b = we_b && !(ZERO_REG && (waddr_b == '0));

  // Port B is written last so it wins an address collision with port A.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
      busy <= '0;
    end else begin
      if (wr_ok_a) mem[waddr_a] <= wdata_a;
      if (wr_ok_b) mem[waddr_b] <= wdata_b;
      for (int r = 0; r < DEPTH; r++) begin
        if (iss_v && (iss_addr == ADDR_W'(r)) && !(ZERO_REG && (r == 0)))
          busy[r] <= 1'b1;
        else if ((we_a && (waddr_a == ADDR_W'(r))) || (we_b && (waddr_b == ADDR_W'(r))))
          busy[r] <= 1'b0;
      end
    end
  end

  assign busy_vec = busy;

  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic              hit_a, hit_b;
    rdata = '0;
    rbusy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra    = raddr[i*ADDR_W +: ADDR_W];
      hit_a = we_a && (waddr_a == ra);
      hit_b = we_b && (waddr_b == ra);
      if (rst && re[i] && !(ZERO_REG && (ra == '0))) begin
        if (hit_b)      rdata[i*DATA_W +: DATA_W] = wdata_b;
        else if (hit_a) rdata[i*DATA_W +: DATA_W] = wdata_a;
        else            rdata[i*DATA_W +: DATA_W] = mem[ra];
        // A same-cycle write to the register is bypassed, so it is not busy.
        rbusy[i] = busy[ra] && !(hit_a || hit_b);
      end
    end
  end

endmodule
